// File: rtl/rtc_pkg.sv
// rtc_pkg: shared field limits, widths and display helpers for the RTC core
package rtc_pkg;
   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;
   localparam int HOUR_W   = 5;
   localparam int MIN_W    = 6;
   localparam int SEC_W    = 6;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic              pm;
   } disp_hour_t;

   function automatic logic [7:0] bin2bcd8(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

   function automatic disp_hour_t to_12h(input logic [HOUR_W-1:0] h, input logic en);
      disp_hour_t d;
      d.pm   = en && h >= 5'd12;
      d.hour = !en ? h : h == 5'd0 ? 5'd12 : h > 5'd12 ? h - 5'd12 : h;
      return d;
   endfunction
endpackage

// File: rtl/rtc_mod_counter.sv
// rtc_mod_counter: modulo-(MAX+1) counter with load and combinational carry
module rtc_mod_counter #(
   parameter int MAX = 59,
   parameter int W   = 6
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] val,
   output logic         carry
);
   assign carry = inc && val == W'(MAX);

   // load has priority over increment; wrap to zero at MAX
   always_ff @(posedge clock or negedge reset)
      if (!reset) val <= '0;
      else if (load) val <= load_val;
      else if (inc) val <= carry ? '0 : val + 1'b1;
endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: prescaled hh:mm:ss clock with BCD display; minute alarm present when RTC_ALARM_EN is defined
module rtc_timekeeper
   import rtc_pkg::*;
#(
   parameter int TICK_DIV = 65536
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              mode_12h,
   input  logic              set_valid,
   input  logic [HOUR_W-1:0] set_hour,
   input  logic [MIN_W-1:0]  set_min,
   input  logic [SEC_W-1:0]  set_sec,
   output logic              set_err,
   input  logic              alarm_set,
   input  logic [HOUR_W-1:0] alarm_hour,
   input  logic [MIN_W-1:0]  alarm_min,
   input  logic              alarm_ack,
   output logic              alarm_fire,
   output logic              sec_tick,
   output logic [7:0]        hour_bcd,
   output logic [7:0]        min_bcd,
   output logic [7:0]        sec_bcd,
   output logic              pm
);
   localparam int CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0]  div_r;
   logic [HOUR_W-1:0] hour_r;
   logic [MIN_W-1:0]  min_r;
   logic [SEC_W-1:0]  sec_r;
   logic              tick, set_ok, load, inc, alarm_err;
   logic              sec_carry, min_carry, hour_carry;
   disp_hour_t        disp;

   assign tick   = run && div_r == CNT_W'(TICK_DIV - 1);
   assign set_ok = set_hour <= HOUR_W'(HOUR_MAX) && set_min <= MIN_W'(MIN_MAX) && set_sec <= SEC_W'(SEC_MAX);
   assign load   = set_valid && set_ok;
   assign inc    = tick && !load;
   assign disp   = to_12h(hour_r, mode_12h);

   // prescaler: restarts on an accepted load so the next second is a full period away
   always_ff @(posedge clock or negedge reset)
      if (!reset) div_r <= '0;
      else if (load) div_r <= '0;
      else if (run) div_r <= tick ? '0 : div_r + 1'b1;

   rtc_mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
      .clock(clock), .reset(reset), .inc(inc), .load(load),
      .load_val(set_sec), .val(sec_r), .carry(sec_carry));

   rtc_mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
      .clock(clock), .reset(reset), .inc(sec_carry), .load(load),
      .load_val(set_min), .val(min_r), .carry(min_carry));

   rtc_mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
      .clock(clock), .reset(reset), .inc(min_carry), .load(load),
      .load_val(set_hour), .val(hour_r), .carry(hour_carry));

`ifdef RTC_ALARM_EN
   logic [HOUR_W-1:0] al_hour, nxt_hour;
   logic [MIN_W-1:0]  al_min, nxt_min;
   logic              armed, al_ok, match;

   assign al_ok     = alarm_hour <= HOUR_W'(HOUR_MAX) && alarm_min <= MIN_W'(MIN_MAX);
   assign alarm_err = alarm_set && !al_ok;
   assign nxt_min   = min_carry ? '0 : min_r + 1'b1;
   assign nxt_hour  = hour_carry ? '0 : min_carry ? hour_r + 1'b1 : hour_r;
   // a match is judged on the time a tick is about to produce, so loads never fire it
   assign match     = armed && sec_carry && nxt_min == al_min && nxt_hour == al_hour;

   // alarm registers; a match in the same cycle as an ack keeps the flag set
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         al_hour    <= '0;
         al_min     <= '0;
         armed      <= 1'b0;
         alarm_fire <= 1'b0;
      end else begin
         if (alarm_set && al_ok) begin
            al_hour <= alarm_hour;
            al_min  <= alarm_min;
            armed   <= 1'b1;
         end
         alarm_fire <= match || (alarm_fire && !alarm_ack);
      end
`else
   logic unused_alarm;
   assign unused_alarm = ^{alarm_set, alarm_hour, alarm_min, alarm_ack, hour_carry};
   assign alarm_err    = 1'b0;
   assign alarm_fire   = 1'b0;
`endif

   // registered status pulses and display digits, one cycle behind the internal time
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         sec_tick <= 1'b0;
         set_err  <= 1'b0;
         hour_bcd <= 8'h00;
         min_bcd  <= 8'h00;
         sec_bcd  <= 8'h00;
         pm       <= 1'b0;
      end else begin
         sec_tick <= inc;
         set_err  <= (set_valid && !set_ok) || alarm_err;
         hour_bcd <= bin2bcd8({1'b0, disp.hour});
         min_bcd  <= bin2bcd8(min_r);
         sec_bcd  <= bin2bcd8(sec_r);
         pm       <= disp.pm;
      end
endmodule
